// File: rtl/iob_pwbuf_if.sv
// Signal bundle between CPU bus-cycle decode, the posted-write buffer and the IOB master.
// The slave modport is the buffer's view; the master modport drives it.
interface iob_pwbuf_if;
  logic        BACT;
  logic        IOCS;
  logic        IOPWCS;
  logic        nWE;
  logic [23:1] A;
  logic [15:0] D;
  logic        nUDS;
  logic        nLDS;
  logic        CPUAck;
  logic        IOStall;
  logic        IOReq;
  logic [23:1] IOAddr;
  logic [15:0] IOData;
  logic        IOnUDS;
  logic        IOnLDS;
  logic        IOnWE;
  logic        IOAck;
  logic        Full;
  logic        Empty;

  modport slave (
    input  BACT, IOCS, IOPWCS, nWE, A, D, nUDS, nLDS, IOAck,
    output CPUAck, IOStall, IOReq, IOAddr, IOData, IOnUDS, IOnLDS, IOnWE, Full, Empty
  );

  modport master (
    output BACT, IOCS, IOPWCS, nWE, A, D, nUDS, nLDS, IOAck,
    input  CPUAck, IOStall, IOReq, IOAddr, IOData, IOnUDS, IOnLDS, IOnWE, Full, Empty
  );
endinterface

// File: rtl/iob_pwbuf.sv
// Posted-write buffer: captures eligible CPU writes, acks them at once, drains them in order to the IOB.
// Optional IOPW_COALESCE_EN merges a write to the tail entry's address instead of enqueuing it.
module iob_pwbuf #(
  parameter int DEPTH = 2
) (
  input logic       CLK,
  input logic       RES,
  iob_pwbuf_if.slave bus
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [23:1] addr_mem [DEPTH];
  logic [15:0] data_mem [DEPTH];
  logic        uds_mem  [DEPTH];
  logic        lds_mem  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          empty;
  logic          taken;
  logic          cpu_ack;
  logic          write_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic          issue;

  // Taken blocks a second accept while the same CPU bus cycle is still active.
  assign write_ok = bus.BACT && bus.IOPWCS && !bus.nWE && (!bus.nUDS || !bus.nLDS) && !taken;

`ifdef IOPW_COALESCE_EN
  logic [PW-1:0] tail_last;
  logic          merge;

  // count>=2 keeps the merge target away from the head that may be on the bus.
  assign tail_last = tail - PW'(1);
  assign merge     = write_ok && (count >= CW'(2)) && (addr_mem[tail_last] == bus.A);
  assign accept    = write_ok && (!full || merge);
  assign push      = accept && !merge;
`else
  assign accept    = write_ok && !full;
  assign push      = accept;
`endif

  assign pop        = issue && bus.IOAck;
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[tail] <= bus.A;
      data_mem[tail] <= bus.D;
      uds_mem[tail]  <= bus.nUDS;
      lds_mem[tail]  <= bus.nLDS;
    end
`ifdef IOPW_COALESCE_EN
    else if (merge) begin
      if (!bus.nUDS) data_mem[tail_last][15:8] <= bus.D[15:8];
      if (!bus.nLDS) data_mem[tail_last][7:0]  <= bus.D[7:0];
      uds_mem[tail_last] <= uds_mem[tail_last] & bus.nUDS;
      lds_mem[tail_last] <= lds_mem[tail_last] & bus.nLDS;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      taken   <= 1'b0;
      cpu_ack <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count   <= count_next;
      full    <= (count_next == CW'(DEPTH));
      empty   <= (count_next == '0);
      taken   <= bus.BACT && (taken || accept);
      cpu_ack <= accept;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) state <= IDLE;
    else     state <= state_next;
  end

  // DONE inserts one idle bus cycle between consecutive drain requests.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE:    if (!empty) state_next = ISSUE;
      ISSUE: begin
        issue = 1'b1;
        if (bus.IOAck) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.CPUAck  = cpu_ack;
  assign bus.IOStall = bus.BACT && bus.IOCS && !bus.IOPWCS && !empty;
  assign bus.IOReq   = issue;
  assign bus.IOnWE   = !issue;
  assign bus.IOAddr  = issue ? addr_mem[head] : '0;
  assign bus.IOData  = issue ? data_mem[head] : '0;
  assign bus.IOnUDS  = issue ? uds_mem[head] : 1'b1;
  assign bus.IOnLDS  = issue ? lds_mem[head] : 1'b1;
  assign bus.Full    = full;
  assign bus.Empty   = empty;

endmodule

// File: tb/tb_iob_pwbuf.sv
// Self-checking bench for iob_pwbuf: table of CPU cycles plus hand-written corner sequences,
// with a scoreboard of expected drain writes checked by an IOB responder.
module tb_iob_pwbuf;

  logic CLK = 1'b0;
  logic RES;

  iob_pwbuf_if bus();

  iob_pwbuf #(.DEPTH(2)) dut (
    .CLK(CLK),
    .RES(RES),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [22:0] a;
    logic [15:0] d;
    logic        uds;
    logic        lds;
    logic        nwe;
    logic        pwcs;
    int          cycles;
    int          expAcks;
    logic        expStall;
  } vec_t;

  typedef struct {
    logic [22:0] a;
    logic [15:0] d;
    logic        uds;
    logic        lds;
  } wr_t;

  wr_t sb[$];
  wr_t expW;
  int  total = 0;
  int  bad = 0;
  bit  ackEn = 1'b0;
  int  acksGiven = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input wr_t w, input int cyc, input int expAcks);
    vec_t v;
    v = '{w.a, w.d, w.uds, w.lds, 1'b0, 1'b1, cyc, expAcks, 1'b0};
    return v;
  endfunction

  // Runs one CPU bus cycle for v.cycles clocks, then releases BACT for one clock.
  task automatic applyStimulus(input vec_t v, input string name, output int acks, output int first);
    acks  = 0;
    first = -1;
    bus.A      = v.a;
    bus.D      = v.d;
    bus.nUDS   = v.uds;
    bus.nLDS   = v.lds;
    bus.nWE    = v.nwe;
    bus.IOPWCS = v.pwcs;
    bus.IOCS   = 1'b1;
    bus.BACT   = 1'b1;
    #1;
    checkOutput({name, "_stall"}, 32'(bus.IOStall), 32'(v.expStall));
    for (int i = 0; i <= v.cycles; i++) begin
      if (i == v.cycles) bus.BACT = 1'b0;
      @(posedge CLK); #1;
      if (bus.CPUAck) begin
        acks++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic waitEmpty(input int maxCycles, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      @(posedge CLK); #1;
      if (bus.Empty && !bus.IOReq) done = 1'b1;
    end
    checkOutput({name, "_drained"}, 32'(done), 32'd1);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  // IOB master model: acks each request after checking it against the scoreboard head.
  always begin
    @(posedge CLK); #2;
    if (RES || bus.IOAck) begin
      bus.IOAck = 1'b0;
    end else if (bus.IOReq && ackEn) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_issue: got IOReq with IOAddr=0x%0h, expected no request", bus.IOAddr);
      end else begin
        expW = sb.pop_front();
        checkOutput("io_addr", 32'(bus.IOAddr), 32'(expW.a));
        checkOutput("io_data", 32'(bus.IOData), 32'(expW.d));
        checkOutput("io_nuds", 32'(bus.IOnUDS), 32'(expW.uds));
        checkOutput("io_nlds", 32'(bus.IOnLDS), 32'(expW.lds));
        checkOutput("io_nwe",  32'(bus.IOnWE), 32'd0);
      end
      bus.IOAck = 1'b1;
      acksGiven++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    wr_t  w1, w2, w3, w4, w5, w6, w7, w8, tmp;
    int   acks, first, stuck, fz, ca, base, dropAt, seen;

    vecs[0] = '{23'h1FA100, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1, 1'b0};
    vecs[1] = '{23'h000001, 16'h12AB, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1, 1'b0};
    vecs[2] = '{23'h7FFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1, 1'b0};
    vecs[3] = '{23'h0F0F0F, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 3, 0, 1'b0};
    vecs[4] = '{23'h123456, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0};
    vecs[5] = '{23'h2AAAAA, 16'h0F0F, 1'b1, 1'b1, 1'b0, 1'b1, 3, 0, 1'b0};
    vecs[6] = '{23'h3C3C3C, 16'hCAFE, 1'b0, 1'b0, 1'b0, 1'b1, 10, 1, 1'b0};
    vecs[7] = '{23'h400000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1, 1'b0};

    RES = 1'b1;
    bus.BACT = 1'b0; bus.IOCS = 1'b0; bus.IOPWCS = 1'b0; bus.nWE = 1'b1;
    bus.A = '0; bus.D = '0; bus.nUDS = 1'b1; bus.nLDS = 1'b1; bus.IOAck = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_cpuack", 32'(bus.CPUAck), 32'd0);
    checkOutput("rst_ioreq",  32'(bus.IOReq), 32'd0);
    checkOutput("rst_empty",  32'(bus.Empty), 32'd1);
    checkOutput("rst_full",   32'(bus.Full), 32'd0);
    checkOutput("rst_ioaddr", 32'(bus.IOAddr), 32'd0);
    checkOutput("rst_iodata", 32'(bus.IOData), 32'd0);
    checkOutput("rst_ionuds", 32'(bus.IOnUDS), 32'd1);
    checkOutput("rst_ionlds", 32'(bus.IOnLDS), 32'd1);
    checkOutput("rst_ionwe",  32'(bus.IOnWE), 32'd1);
    RES = 1'b0;
    @(posedge CLK); #1;

    $display("[TB] single posted write");
    ackEn = 1'b1;
    sb.push_back('{23'h1FA100, 16'hBEEF, 1'b0, 1'b0});
    bus.A = 23'h1FA100; bus.D = 16'hBEEF; bus.nUDS = 1'b0; bus.nLDS = 1'b0;
    bus.nWE = 1'b0; bus.IOPWCS = 1'b1; bus.IOCS = 1'b1; bus.BACT = 1'b1;
    @(posedge CLK); #1;
    checkOutput("single_cpuack", 32'(bus.CPUAck), 32'd1);
    checkOutput("single_empty0", 32'(bus.Empty), 32'd0);
    checkOutput("single_ioreq_early", 32'(bus.IOReq), 32'd0);
    @(posedge CLK); #1;
    checkOutput("single_cpuack_pulse", 32'(bus.CPUAck), 32'd0);
    checkOutput("single_ioreq", 32'(bus.IOReq), 32'd1);
    checkOutput("single_ioaddr", 32'(bus.IOAddr), 32'h1FA100);
    checkOutput("single_iodata", 32'(bus.IOData), 32'hBEEF);
    bus.BACT = 1'b0;
    @(posedge CLK); #1;
    checkOutput("single_ioreq_drop", 32'(bus.IOReq), 32'd0);
    checkOutput("single_empty1", 32'(bus.Empty), 32'd1);
    repeat (2) @(posedge CLK);
    #1;

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].expAcks > 0)
        sb.push_back('{vecs[i].a, vecs[i].d, vecs[i].uds, vecs[i].lds});
      applyStimulus(vecs[i], $sformatf("vec%0d", i), acks, first);
      checkOutput($sformatf("vec%0d_acks", i), 32'(acks), 32'(vecs[i].expAcks));
      if (vecs[i].expAcks > 0)
        checkOutput($sformatf("vec%0d_ack_cycle", i), 32'(first), 32'd0);
      waitEmpty(40, $sformatf("vec%0d", i));
    end

    $display("[TB] fill to full");
    ackEn = 1'b0;
    w1 = '{23'h010000, 16'h1111, 1'b0, 1'b0};
    w2 = '{23'h020000, 16'h2222, 1'b0, 1'b1};
    w3 = '{23'h030000, 16'h3333, 1'b1, 1'b0};
    sb.push_back(w1);
    applyStimulus(mkVec(w1, 2, 1), "full_w1", acks, first);
    checkOutput("full_w1_ack", 32'(acks), 32'd1);
    sb.push_back(w2);
    applyStimulus(mkVec(w2, 2, 1), "full_w2", acks, first);
    checkOutput("full_w2_ack", 32'(acks), 32'd1);
    checkOutput("full_flag", 32'(bus.Full), 32'd1);
    sb.push_back(w3);
    bus.A = w3.a; bus.D = w3.d; bus.nUDS = w3.uds; bus.nLDS = w3.lds;
    bus.nWE = 1'b0; bus.IOPWCS = 1'b1; bus.BACT = 1'b1;
    stuck = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (bus.CPUAck) stuck++;
    end
    checkOutput("full_wait_noack", 32'(stuck), 32'd0);
    checkOutput("full_still", 32'(bus.Full), 32'd1);
    ackEn = 1'b1;
    fz = -1;
    ca = -1;
    for (int i = 0; i < 20 && ca < 0; i++) begin
      @(posedge CLK); #1;
      if (!bus.Full && fz < 0) fz = i;
      if (bus.CPUAck) ca = i;
    end
    checkOutput("full_accept_seen", 32'(ca >= 0), 32'd1);
    checkOutput("full_accept_timing", 32'(ca), 32'(fz + 1));
    bus.BACT = 1'b0;
    waitEmpty(60, "full");

    $display("[TB] ordering stall");
    ackEn = 1'b0;
    w4 = '{23'h050000, 16'h4444, 1'b0, 1'b0};
    w5 = '{23'h060000, 16'h5555, 1'b0, 1'b0};
    sb.push_back(w4);
    applyStimulus(mkVec(w4, 2, 1), "ord_w4", acks, first);
    checkOutput("ord_w4_ack", 32'(acks), 32'd1);
    sb.push_back(w5);
    applyStimulus(mkVec(w5, 2, 1), "ord_w5", acks, first);
    checkOutput("ord_w5_ack", 32'(acks), 32'd1);
    bus.A = 23'h070000; bus.nWE = 1'b0; bus.IOCS = 1'b1; bus.IOPWCS = 1'b0; bus.BACT = 1'b1;
    #1;
    checkOutput("ord_stall_start", 32'(bus.IOStall), 32'd1);
    base = acksGiven;
    ackEn = 1'b1;
    dropAt = -1;
    for (int i = 0; i < 40 && dropAt < 0; i++) begin
      @(posedge CLK); #1;
      if (!bus.IOStall) begin
        dropAt = i;
        checkOutput("ord_pops_before_drop", 32'(acksGiven - base), 32'd2);
        checkOutput("ord_empty_at_drop", 32'(bus.Empty), 32'd1);
      end
    end
    checkOutput("ord_stall_dropped", 32'(dropAt >= 0), 32'd1);
    bus.BACT = 1'b0;
    bus.IOPWCS = 1'b1;
    waitEmpty(20, "ord");

    $display("[TB] same-address byte writes on a full buffer");
    ackEn = 1'b0;
    w6 = '{23'h080000, 16'h6666, 1'b0, 1'b0};
    w7 = '{23'h081000, 16'h0099, 1'b1, 1'b0};
    sb.push_back(w6);
    applyStimulus(mkVec(w6, 2, 1), "coal_w6", acks, first);
    checkOutput("coal_w6_ack", 32'(acks), 32'd1);
    sb.push_back(w7);
    applyStimulus(mkVec(w7, 2, 1), "coal_w7", acks, first);
    checkOutput("coal_w7_ack", 32'(acks), 32'd1);
`ifdef IOPW_COALESCE_EN
    applyStimulus('{w7.a, 16'h12AA, 1'b0, 1'b1, 1'b0, 1'b1, 4, 1, 1'b0}, "coal_hi", acks, first);
    checkOutput("coal_hi_ack", 32'(acks), 32'd1);
    checkOutput("coal_hi_full", 32'(bus.Full), 32'd1);
    applyStimulus('{w7.a, 16'h5534, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1, 1'b0}, "coal_lo", acks, first);
    checkOutput("coal_lo_ack", 32'(acks), 32'd1);
    checkOutput("coal_lo_full", 32'(bus.Full), 32'd1);
    tmp = sb.pop_back();
    tmp.d = 16'h1234;
    tmp.uds = 1'b0;
    tmp.lds = 1'b0;
    sb.push_back(tmp);
`else
    applyStimulus('{w7.a, 16'h12AA, 1'b0, 1'b1, 1'b0, 1'b1, 4, 0, 1'b0}, "coal_hi", acks, first);
    checkOutput("coal_hi_noack", 32'(acks), 32'd0);
    checkOutput("coal_hi_full", 32'(bus.Full), 32'd1);
    applyStimulus('{w7.a, 16'h5534, 1'b1, 1'b0, 1'b0, 1'b1, 4, 0, 1'b0}, "coal_lo", acks, first);
    checkOutput("coal_lo_noack", 32'(acks), 32'd0);
`endif
    ackEn = 1'b1;
    waitEmpty(60, "coal");

    $display("[TB] reset mid-drain");
    ackEn = 1'b0;
    w8 = '{23'h0ABCDE, 16'h8888, 1'b0, 1'b0};
    sb.push_back(w8);
    applyStimulus(mkVec(w8, 2, 1), "rmd_w8", acks, first);
    checkOutput("rmd_ack", 32'(acks), 32'd1);
    checkOutput("rmd_pre_ioreq", 32'(bus.IOReq), 32'd1);
    #2;
    RES = 1'b1;
    #1;
    checkOutput("rmd_ioreq", 32'(bus.IOReq), 32'd0);
    checkOutput("rmd_empty", 32'(bus.Empty), 32'd1);
    checkOutput("rmd_cpuack", 32'(bus.CPUAck), 32'd0);
    checkOutput("rmd_full", 32'(bus.Full), 32'd0);
    sb.delete();
    @(posedge CLK); #1;
    RES = 1'b0;
    ackEn = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (bus.IOReq) seen++;
    end
    checkOutput("rmd_never_issued", 32'(seen), 32'd0);
    checkOutput("rmd_empty_after", 32'(bus.Empty), 32'd1);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_pwbuf.md
# iob_pwbuf

Posted-write buffer between CPU bus-cycle decode and the IOB-domain bus master. Write cycles flagged for posting (video-RAM writes, only when QoS is disabled) are captured into a small FIFO and acknowledged to the CPU immediately. The buffer then drains them to the slow I/O bus through a request/acknowledge handshake. Non-posted I/O cycles are stalled until the buffer is empty, which preserves CPU write ordering.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; legal values 2 or 4.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RES  in  1  reset, asynchronous, active-high.
- BACT  in  1  CPU bus cycle active (AS asserted, already synchronized).
- IOCS  in  1  cycle targets the IOB domain.
- IOPWCS  in  1  cycle is eligible for posting.
- nWE  in  1  CPU write strobe, active-low.
- A  in  23  CPU address [23:1].
- D  in  16  CPU write data.
- nUDS, nLDS  in  1 each  CPU data strobes, active-low.
- CPUAck  out  1  one-cycle pulse; terminates a posted CPU write (feeds DTACK logic).
- IOStall  out  1  blocks the IOB master from starting a non-posted cycle.
- IOReq  out  1  drain request to the IOB master.
- IOAddr  out  23  head-entry address.
- IOData  out  16  head-entry data.
- IOnUDS, IOnLDS, IOnWE  out  1 each  head-entry strobes; IOnWE is low while IOReq is high.
- IOAck  in  1  IOB master finished the requested write; sampled high for one cycle.
- Full, Empty  out  1 each  registered FIFO status.

## Operation
- Reset: FIFO pointers and count are 0, Empty=1, Full=0, FSM=IDLE, Taken=0, CPUAck=0, IOReq=0, IOAddr=0, IOData=0, IOnUDS=IOnLDS=IOnWE=1. Writes already in the FIFO when reset asserts are discarded.
- Taken flag:
  - Set on accept.
  - Cleared on any cycle with BACT=0.
  - Guarantees at most one accept per CPU bus cycle.
- Accept condition: BACT & IOPWCS & !nWE & (!nUDS | !nLDS) & !Taken & !Full.
- On accept:
  - Enqueue {A, D, nUDS, nLDS} at the tail.
  - Set Taken.
  - Register CPUAck=1 for the next cycle only.
- If Full, the CPU cycle waits with no CPUAck. It is accepted on the first cycle Full=0.
- Non-posted stall: IOStall = BACT & IOCS & !IOPWCS & !Empty, combinational. Once Empty, the IOB master runs the cycle directly; the buffer does nothing.
- Drain FSM:
  - IDLE: go to ISSUE when !Empty.
  - ISSUE:
    - IOReq=1, with IOAddr/IOData/strobes driven from the head and held stable.
    - On IOAck=1: pop head, go to DONE.
  - DONE: IOReq=0 for one cycle, then go to IDLE.
- Count update: a simultaneous enqueue and pop leaves count unchanged, and the pointers advance independently. Pointers wrap modulo DEPTH.
- Full = (count==DEPTH). Empty = (count==0). Both are registered from the next count.
- IOAck outside ISSUE is ignored.

## Timing
- Accept sampled at edge N → CPUAck high for cycle N+1 → Empty=0 from N+1.
- FSM leaves IDLE at edge N+1, so IOReq is high from cycle N+2. Enqueue-to-IOReq latency is 2 cycles.
- IOAck sampled at edge M → IOReq low from M+1 (DONE) → earliest next IOReq from M+3. Minimum issue spacing is 3 cycles plus the IOAck wait.
- Pop at edge M updates Full/Empty from M+1. A CPU write waiting on Full can be accepted at edge M+1.
- IOStall follows Empty combinationally, so it drops in the cycle Empty goes to 1.

## Configuration
- IOPW_COALESCE_EN defined:
  - An accepting write whose A equals the tail entry's address, with count≥2 (tail is not the head being issued), merges into the tail instead of enqueuing.
  - Data lanes with the incoming strobe low are overwritten.
  - Tail strobes become the AND of old and new.
  - Count is unchanged and CPUAck pulses as normal.
  - A merge is permitted when Full.
- IOPW_COALESCE_EN undefined: every accepted write occupies a new entry, and the Full gating applies to all writes.

## Test plan
- Reset mid-drain: one entry in ISSUE, assert RES → IOReq=0, Empty=1, CPUAck=0 immediately, and the entry is never issued.
- Single posted write: A=0x1FA100, D=0xBEEF, nUDS=nLDS=0 → CPUAck pulse 1 cycle after accept; IOReq 2 cycles after accept with IOAddr=0x1FA100, IOData=0xBEEF; IOAck → Empty=1.
- Fill to Full (DEPTH=2), IOAck held low, third write pending → no CPUAck until the first IOAck. The third write is accepted the cycle after the pop and drains in FIFO order.
- Ordering: two posted writes, then a non-posted IOCS cycle → IOStall=1 until the second IOAck pop, then IOStall=0.
- Long BACT: a posted write with BACT held 10 cycles → exactly one enqueue and one CPUAck.
- Coalesce (IOPW_COALESCE_EN, two entries queued): byte write nUDS=0, D=0x12xx, then nLDS=0, D=0xxx34, both to the tail address → count stays 2, and the tail issues D=0x1234 with both strobes low. Without the macro, the same stimulus stalls on Full.
